param_seq_detector: RTL
=======================

Name: param_seq_detector

Overview:
Parametrised Mealy serial-pattern detector and the successor to the fixed 1010 detector. Pattern width is set by a parameter, and the pattern itself can be loaded at run time. Overlapping or non-overlapping detection is selected by an input, and a saturating match counter and a registered match flag are added. It sits on a 1-bit serial input stream and feeds control logic that needs both a same-cycle match indication and a running match total.

Parameters:
PAT_W, 4, pattern length in bits (legal range 2..16).
PATTERN, 4'b1010, reset value of the pattern register; the MSB is the first bit received.
CNT_W, 8, width of the match counter.

Ports:
clk  input  1  rising-edge clock
reset  input  1  synchronous, active-low reset (sampled on the rising edge of clk)
en  input  1  bit-valid; x is consumed only when en=1
x  input  1  serial data bit
overlap  input  1  1 = overlapping detection, 0 = non-overlapping
pat_load  input  1  load pat_in into the pattern register
pat_in  input  PAT_W  new pattern, MSB first
z  output  1  Mealy match output, combinational on the current x
z_q  output  1  z registered (one-cycle-delayed copy)
match_count  output  CNT_W  number of matches since reset or the last pattern load
count_sat  output  1  high while match_count is all-ones

Behaviour:
- Reset (reset=0 at a clk edge):
  - hist <= 0, fill <= 0, pat <= PATTERN, match_count <= 0, z_q <= 0.
  - z is forced 0 while reset=0.
  - Reset applied mid-sequence discards all partial history.
- State:
  - hist: PAT_W-1 bit shift register of previously accepted bits, newest bit in the LSB.
  - fill: counter 0..PAT_W-1 giving the number of valid history bits.
- Match term: m = en & pat_load==0 & (fill==PAT_W-1) & ({hist, x} == pat).
- z = m (Mealy).
  - z asserts in the same cycle the final pattern bit is present on x.
  - No cycle latency from x to z.
- z_q <= m on each clk edge.
  - Latency from the final bit to z_q is 1 cycle.
- Accepted bit (en=1, pat_load=0, m=0):
  - hist <= {hist[PAT_W-3:0], x}.
  - fill <= min(fill+1, PAT_W-1).
- Match (m=1):
  - overlap=1: shift as for a non-match; fill stays at PAT_W-1, so suffixes of the match can begin the next match.
  - overlap=0: hist <= 0, fill <= 0; the next match needs PAT_W fresh bits.
  - match_count <= match_count+1, saturating at 2^CNT_W-1 (no wrap).
- en=0: hist, fill and match_count hold; z=0; z_q <= 0.
- pat_load=1 (takes priority over en):
  - pat <= pat_in, hist <= 0, fill <= 0, match_count <= 0.
  - z=0 in the load cycle.
  - The new pattern is active from the next cycle.
- The overlap input may change on any cycle. It affects only the history update at a match edge and takes effect immediately.
- count_sat = (match_count == {CNT_W{1'b1}}), combinational.
- Simultaneous reset=0 and pat_load=1: reset wins, so pat = PATTERN.
- Self-overlapping patterns (e.g. 1111, 1010) must produce every overlapping hit in overlap mode.
- A pattern with no self-overlap (e.g. 1000) gives identical results in both modes.

Test Plan:
- Reset, then overlap=1, en=1, pattern 1010, x stream 1,0,1,0,1,0,1,0 (one bit per cycle) -> z=1 on bits 4, 6, 8; z_q=1 one cycle after each; match_count=3.
- Same stream with overlap=0 -> z=1 on bits 4 and 8 only; match_count=2.
- Gaps with en: stream 1,0,[en=0 for 3 cycles with x toggling],1,0 -> single z on the final 0; z=0 during the en=0 cycles; match_count=1.
- pat_load with pat_in=4'b1111 after two matches -> match_count=0; then x=1 for 6 cycles with overlap=1 -> z on bits 4, 5, 6; match_count=3. With overlap=0 -> z on bit 4 only.
- Reset mid-pattern: send 1,0,1, pull reset=0 for one cycle, send 0 -> no z; then 1,0,1,0 -> z on the last 0; pattern is back to 1010 after reset.
- Saturation, CNT_W=2, overlap=1, pattern 1111: stream x=1 for 10 cycles -> match_count reaches 3 and holds at 3; count_sat=1 from the third match; z keeps pulsing on each further bit.

Source files
------------

// File: rtl/param_seq_detector.sv
// Parametrised Mealy serial-pattern detector with run-time loadable pattern,
// overlap/non-overlap modes, a registered match flag and a saturating match counter.
module param_seq_detector #(
  parameter int               PAT_W   = 4,
  parameter logic [PAT_W-1:0] PATTERN = 4'b1010,
  parameter int               CNT_W   = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             x,
  input  logic             overlap,
  input  logic             pat_load,
  input  logic [PAT_W-1:0] pat_in,
  output logic             z,
  output logic             z_q,
  output logic [CNT_W-1:0] match_count,
  output logic             count_sat
);

  localparam int            FW   = $clog2(PAT_W);
  localparam logic [FW-1:0] FULL = FW'(PAT_W - 1);

  logic [PAT_W-2:0] hist;
  logic [FW-1:0]    fill;
  logic [PAT_W-1:0] pat;
  logic [PAT_W-1:0] window;
  logic             m;

  // Candidate window: accepted history followed by the bit on x this cycle.
  assign window    = {hist, x};
  assign m         = reset & en & ~pat_load & (fill == FULL) & (window == pat);
  assign z         = m;
  assign count_sat = &match_count;

  always_ff @(posedge clk) begin
    if (!reset) begin
      hist        <= '0;
      fill        <= '0;
      pat         <= PATTERN;
      match_count <= '0;
      z_q         <= 1'b0;
    end else if (pat_load) begin
      pat         <= pat_in;
      hist        <= '0;
      fill        <= '0;
      match_count <= '0;
      z_q         <= 1'b0;
    end else begin
      z_q <= m;
      if (en) begin
        // Non-overlapping mode drops the whole history after a hit.
        if (m && !overlap) begin
          hist <= '0;
          fill <= '0;
        end else begin
          hist <= window[PAT_W-2:0];
          if (fill != FULL) fill <= fill + 1'b1;
        end
        if (m && !count_sat) match_count <= match_count + 1'b1;
      end
    end
  end

endmodule
